// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state type and default sizing for the iterative right shifter
package shift_pkg;

    typedef enum logic [1:0] {SR_IDLE, SR_SHIFT, SR_DONE} sr_state_t;

    localparam int SHIFT_WIDTH   = 32;
    localparam int SHIFT_SHAMT_W = $clog2(SHIFT_WIDTH);

endpackage

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - single-bit 2:1 multiplexer
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/sr_stage.sv
// rtl/sr_stage.sv - one combinational right-shift stage; distance 2^stage, bypassed when en is low
module sr_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   d,
    input  logic [SHAMT_W-1:0] stage,
    input  logic               en,
    input  logic               fill,
    output logic [WIDTH-1:0]   q
);

    logic [SHAMT_W-1:0][WIDTH-1:0] cand;
    logic [WIDTH-1:0]              shifted;

    // cand[s] is d shifted right by 2^s with fill entering from the top
    for (genvar s = 0; s < SHAMT_W; s++) begin : g_dist
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i + (1 << s) < WIDTH) begin : g_src
                assign cand[s][i] = d[i + (1 << s)];
            end else begin : g_fill
                assign cand[s][i] = fill;
            end
        end
    end

    always_comb begin
        shifted = d;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (stage == SHAMT_W'(s)) begin
                shifted = cand[s];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2x1 u_mux (
            .a   (d[i]),
            .b   (shifted[i]),
            .sel (en),
            .y   (q[i])
        );
    end

endmodule

// File: rtl/sr_iterative.sv
// rtl/sr_iterative.sv - multi-cycle SRL/SRA unit, one barrel stage per cycle, valid/ready handshaked
// Define SR_ITERATIVE_SRA_EN to honour arith; otherwise the unit is a pure logical shifter.
module sr_iterative
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z
);

    localparam int SHAMT_W = $clog2(WIDTH);

    sr_state_t          state;
    sr_state_t          state_nxt;
    logic [SHAMT_W-1:0] stage;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   stage_out;
    logic               fill;
    logic               fill_in;
    logic               last_stage;
    logic               unused_inputs;

`ifdef SR_ITERATIVE_SRA_EN
    assign fill_in = arith & x[WIDTH-1];
    assign unused_inputs = ^y[WIDTH-1:SHAMT_W];
`else
    assign fill_in = 1'b0;
    assign unused_inputs = ^{y[WIDTH-1:SHAMT_W], arith};
`endif

    assign last_stage = (stage == SHAMT_W'(SHAMT_W - 1));
    assign in_ready   = (state == SR_IDLE);
    assign out_valid  = (state == SR_DONE);
    assign z          = data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SR_IDLE:  if (in_valid)   state_nxt = SR_SHIFT;
            SR_SHIFT: if (last_stage) state_nxt = SR_DONE;
            SR_DONE:  if (out_ready)  state_nxt = SR_IDLE;
            default:                  state_nxt = SR_IDLE;
        endcase
    end

    // shamt is consumed LSB-first, so bit 0 always enables the current stage
    sr_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .d     (data),
        .stage (stage),
        .en    (shamt[0]),
        .fill  (fill),
        .q     (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            shamt <= '0;
            fill  <= 1'b0;
            stage <= '0;
        end else begin
            case (state)
                SR_IDLE: begin
                    if (in_valid) begin
                        data  <= x;
                        shamt <= y[SHAMT_W-1:0];
                        fill  <= fill_in;
                        stage <= '0;
                    end
                end
                SR_SHIFT: begin
                    data  <= stage_out;
                    shamt <= shamt >> 1;
                    stage <= stage + SHAMT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_iterative.sv
// tb/tb_sr_iterative.sv - directed and randomised scoreboard bench for sr_iterative
module tb_sr_iterative;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int BOUND   = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             arith = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] z;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    sr_iterative #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                                               input logic av);
        int   sh;
        logic f;
        sh = int'(yv[SHAMT_W-1:0]);
`ifdef SR_ITERATIVE_SRA_EN
        f = av;
`else
        f = av & 1'b0;
`endif
        if (f) return WIDTH'($signed(xv) >>> sh);
        return xv >> sh;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_req(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv, input logic av);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("req_timeout", 32'd0, 32'd1);
        x = xv;
        y = yv;
        arith = av;
        in_valid = 1'b1;
        exp_q.push_back(model(xv, yv, av));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        arith = 1'($urandom);
    endtask

    task automatic wait_out(input bit chk_lat);
        int               n = 0;
        logic [WIDTH-1:0] e;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid) check("busy_in_ready", 32'(in_ready), 32'd0);
        end while (!out_valid && n < BOUND);
        if (!out_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            if (chk_lat) check("latency", 32'(n), 32'(SHAMT_W + 1));
            check("excl_in_ready", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("z", z, e);
            end
        end
    endtask

    task automatic release_out(input int hold, input bit pulse);
        logic [WIDTH-1:0] z0;
        z0 = z;
        repeat (hold) begin
            if (pulse) begin
                in_valid = 1'($urandom);
                x = $urandom;
                y = $urandom;
            end
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_z", z, z0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] xr;
        int               n;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", z, 32'd0);
        rst = 1'b0;

        // abort mid-SHIFT
        do_req(32'hFFFF_0000, 32'd3, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_z", z, 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end

        do_req(32'h8000_0001, 32'd4, 1'b0);
        wait_out(1'b1);
        check("srl_const", z, 32'h0800_0000);
        release_out(0, 1'b0);

        do_req(32'h8000_0000, 32'd31, 1'b1);
        wait_out(1'b1);
`ifdef SR_ITERATIVE_SRA_EN
        check("sra31_const", z, 32'hFFFF_FFFF);
`else
        check("sra31_const", z, 32'h0000_0001);
`endif
        release_out(0, 1'b0);

        // backpressure with ignored in_valid pulses
        do_req(32'h1234_5678, 32'hFFFF_FFE8, 1'b0);
        wait_out(1'b1);
        check("bp_const", z, 32'h0012_3456);
        release_out(10, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("bp_idle_in_ready", 32'(in_ready), 32'd1);
            check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        end

        xr = $urandom;
        do_req(xr, 32'd0, 1'b1);
        wait_out(1'b1);
        check("shamt0_z", z, xr);
        release_out(0, 1'b0);
        xr = $urandom | 32'h8000_0000;
        do_req(xr, 32'd32, 1'b1);
        wait_out(1'b1);
        check("y32_z", z, xr);

        // back-to-back: next request held during the DONE handshake
        xr = $urandom;
        out_ready = 1'b1;
        in_valid = 1'b1;
        x = xr;
        y = 32'd7;
        arith = 1'b1;
        exp_q.push_back(model(xr, 32'd7, 1'b1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom;
        wait_out(1'b1);
        release_out(0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            do_req($urandom, $urandom, 1'($urandom));
            wait_out(1'b1);
            n = int'($urandom_range(0, 3));
            release_out(n, 1'b0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
